// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enables, IF/ID flush, ID/EX bubble.
// Define PIPELINE_HAZARD_PERF_EN to add stall_cnt/flush_cnt event counters.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_ropA,
  input  logic [3:0]       id_ropB,
  input  logic             id_ropA_is_reg,
  input  logic             id_ropB_is_reg,
  input  logic             id_is_store,
  input  logic [3:0]       id_rd,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [3:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
`ifdef PIPELINE_HAZARD_PERF_EN
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`else
  output logic             idex_bubble
`endif
);

  typedef enum logic [1:0] {
    RUN, LDSTALL, FLUSH, MEMWAIT
  } state_t;

  localparam logic [2:0] FC_INIT = 3'(FLUSH_DEPTH - 1);
  localparam state_t BR_NEXT = (FLUSH_DEPTH > 1) ? FLUSH : RUN;

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;
  state_t     eff;
  logic [2:0] fcnt_q, fcnt_d;
  logic       hazard;
  logic       memstall;
  logic       uses_rd;

  assign uses_rd =
    (id_ropA_is_reg & (id_ropA == ex_rd)) |
    (id_ropB_is_reg & (id_ropB == ex_rd)) |
    (id_is_store    & (id_rd   == ex_rd));

  assign hazard = ex_valid & ex_is_load & id_valid &
                  (ex_rd != 4'd15) & uses_rd;

  assign memstall = mem_req & ~mem_ready;

  // MEMWAIT exit resumes the frozen state; LDSTALL resumes as RUN
  assign eff = (state_q == MEMWAIT) ? ret_q : state_q;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    fcnt_d      = fcnt_q;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      ret_d       = RUN;
      fcnt_d      = 3'd0;
    end else if (memstall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = MEMWAIT;
      if (state_q != MEMWAIT)
        ret_d = (state_q == FLUSH) ? FLUSH : RUN;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fcnt_d      = FC_INIT;
      state_d     = BR_NEXT;
    end else if (eff == FLUSH) begin
      ifid_flush = 1'b1;
      fcnt_d     = fcnt_q - 3'd1;
      state_d    = (fcnt_q == 3'd1) ? RUN : FLUSH;
    end else if (hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = LDSTALL;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef PIPELINE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl.
// Define PIPELINE_HAZARD_PERF_EN to also check the event counters.
module tb_pipeline_hazard_ctrl;

  localparam int D     = 4;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic       rst;
    logic       id_valid;
    logic [3:0] ropa;
    logic [3:0] ropb;
    logic       ropa_reg;
    logic       ropb_reg;
    logic       is_store;
    logic [3:0] rd;
    logic       ex_valid;
    logic       ex_load;
    logic [3:0] ex_rd;
    logic       br;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  typedef struct packed {
    logic [6:0]       ctl;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  stim_t s = '0;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_bubble;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int rem = 0;
  int sc = 0;
  int fc = 0;
  int cmax = (1 << CNT_W) - 1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.FLUSH_DEPTH(D), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(s.rst),
    .id_valid(s.id_valid),
    .id_ropA(s.ropa),
    .id_ropB(s.ropb),
    .id_ropA_is_reg(s.ropa_reg),
    .id_ropB_is_reg(s.ropb_reg),
    .id_is_store(s.is_store),
    .id_rd(s.rd),
    .ex_valid(s.ex_valid),
    .ex_is_load(s.ex_load),
    .ex_rd(s.ex_rd),
    .ex_branch_taken(s.br),
    .mem_req(s.mreq),
    .mem_ready(s.mrdy),
    .pc_en(pc_en),
    .ifid_en(ifid_en),
    .idex_en(idex_en),
    .exmem_en(exmem_en),
    .memwb_en(memwb_en),
    .ifid_flush(ifid_flush),
`ifdef PIPELINE_HAZARD_PERF_EN
    .idex_bubble(idex_bubble),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`else
    .idex_bubble(idex_bubble)
`endif
  );

`ifndef PIPELINE_HAZARD_PERF_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  // Reference: rem counts IF/ID flush cycles still owed after a branch
  task automatic step(input stim_t n);
    exp_t e;
    bit ld_use;
    bit waitm;
    @(posedge clk);
    #1;
    s = n;
    cyc++;
    ld_use = n.ex_valid && n.ex_load && n.id_valid &&
             n.ex_rd != 4'd15 &&
             ((n.ropa_reg && n.ropa == n.ex_rd) ||
              (n.ropb_reg && n.ropb == n.ex_rd) ||
              (n.is_store && n.rd == n.ex_rd));
    waitm = n.mreq && !n.mrdy;
    e.sc  = CNT_W'(sc);
    e.fc  = CNT_W'(fc);
    e.cyc = cyc;
    if (n.rst) begin
      e.ctl = 7'b0000011;
      rem = 0;
    end else if (waitm) begin
      e.ctl = 7'b0000000;
    end else if (n.br) begin
      e.ctl = 7'b1111111;
      rem = D - 1;
    end else if (rem > 0) begin
      e.ctl = 7'b1111110;
      rem--;
    end else if (ld_use) begin
      e.ctl = 7'b0011101;
    end else begin
      e.ctl = 7'b1111100;
    end
    q.push_back(e);
    if (n.rst) begin
      sc = 0;
      fc = 0;
    end else begin
      if (!e.ctl[6] && sc < cmax) sc++;
      if (e.ctl[1] && fc < cmax) fc++;
    end
  endtask

  function automatic logic [3:0] rreg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 4'd15 : 4'(v);
  endfunction

  // Monitor: outputs are presented every cycle
  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_bubble};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL ctl cyc %0d: got %b required %b",
                 e.cyc, act, e.ctl);
      end
`ifdef PIPELINE_HAZARD_PERF_EN
      checks++;
      if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        errors++;
        $display("FAIL cnt cyc %0d: got %0d/%0d required %0d/%0d",
                 e.cyc, stall_cnt, flush_cnt, e.sc, e.fc);
      end
`endif
    end
  end

  stim_t idle;
  stim_t ld;
  stim_t r;

  initial begin
    idle = '0;
    s = idle;
    s.rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    s = idle;

    // load-use via ropA, then EX holds the bubble
    ld = idle;
    ld.ex_valid = 1'b1;
    ld.ex_load  = 1'b1;
    ld.ex_rd    = 4'd3;
    ld.id_valid = 1'b1;
    ld.ropa     = 4'd3;
    ld.ropa_reg = 1'b1;
    step(ld);
    step(idle);
    // r3 only as immediate
    r = ld;
    r.ropa_reg = 1'b0;
    step(r);
    // load into r15
    r = ld;
    r.ex_rd = 4'd15;
    r.ropa  = 4'd15;
    step(r);
    // store data register
    r = ld;
    r.ropa_reg = 1'b0;
    r.is_store = 1'b1;
    r.rd       = 4'd3;
    step(r);
    step(idle);
    // branch flush sequence
    r = idle;
    r.br = 1'b1;
    step(r);
    repeat (D + 1) step(idle);
    // memory wait 3 cycles then ready
    r = idle;
    r.mreq = 1'b1;
    repeat (3) step(r);
    r.mrdy = 1'b1;
    step(r);
    step(idle);
    // branch + hazard + memstall together
    r = ld;
    r.br   = 1'b1;
    r.mreq = 1'b1;
    repeat (2) step(r);
    r.mrdy = 1'b1;
    step(r);
    r = ld;
    step(r);
    repeat (D) step(idle);
    // memstall in the middle of a flush
    r = idle;
    r.br = 1'b1;
    step(r);
    step(idle);
    r = idle;
    r.mreq = 1'b1;
    repeat (2) step(r);
    repeat (D) step(idle);
    // reset mid-flush
    r = idle;
    r.br = 1'b1;
    step(r);
    step(idle);
    r = idle;
    r.rst = 1'b1;
    step(r);
    repeat (2) step(idle);

    for (int i = 0; i < 3000; i++) begin
      r.rst      = ($urandom_range(0, 59) == 0);
      r.id_valid = ($urandom_range(0, 3) != 0);
      r.ropa     = rreg();
      r.ropb     = rreg();
      r.ropa_reg = $urandom_range(0, 1);
      r.ropb_reg = $urandom_range(0, 1);
      r.is_store = ($urandom_range(0, 3) == 0);
      r.rd       = rreg();
      r.ex_valid = ($urandom_range(0, 3) != 0);
      r.ex_load  = $urandom_range(0, 1);
      r.ex_rd    = rreg();
      r.br       = ($urandom_range(0, 9) == 0);
      r.mreq     = ($urandom_range(0, 3) == 0);
      r.mrdy     = $urandom_range(0, 1);
      step(r);
    end

    @(posedge clk);
    s = idle;
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d left required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
